// File: rtl/mac_tx_scheduler.sv
// Round-robin transmit scheduler: grants one frame source at a time onto a shared
// XGMII-style datapath, inserts an inter-frame gap, and aborts frames that never terminate.
module mac_tx_scheduler #(
    parameter int          N_REQ           = 4,
    parameter int          DATA_WIDTH      = 64,
    parameter int          CTRL_WIDTH      = 8,
    parameter logic [7:0]  IDLE_CODE       = 8'h07,
    parameter logic [7:0]  TERM_CODE       = 8'hFD,
    parameter int          MIN_IFG_WORDS   = 1,
    parameter int          MAX_FRAME_WORDS = 192
) (
    input  logic                          clk,
    input  logic                          i_rst_n,
    input  logic [N_REQ-1:0]              i_req,
    input  logic [N_REQ*DATA_WIDTH-1:0]   i_data,
    input  logic [N_REQ*CTRL_WIDTH-1:0]   i_ctrl,
    output logic [N_REQ-1:0]              o_grant,
    output logic [DATA_WIDTH-1:0]         o_tx_data,
    output logic [CTRL_WIDTH-1:0]         o_tx_ctrl,
    output logic                          o_busy,
    output logic [31:0]                   o_frame_count,
    output logic                          o_abort,
    output logic [$clog2(N_REQ)-1:0]      o_abort_id
);

    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(MAX_FRAME_WORDS + 1);
    localparam logic [DATA_WIDTH-1:0] IDLE_WORD  = {CTRL_WIDTH{IDLE_CODE}};
    localparam logic [DATA_WIDTH-1:0] ABORT_WORD = {{(CTRL_WIDTH-1){IDLE_CODE}}, TERM_CODE};

    typedef enum logic [1:0] {IDLE, SEND, IFG} state_t;

    state_t                state, state_d;
    logic [IDW-1:0]        rr_ptr, rr_ptr_d;
    logic [IDW-1:0]        grant_id, grant_id_d;
    logic [CW-1:0]         word_cnt, word_cnt_d;
    logic [3:0]            ifg_cnt, ifg_cnt_d;
    logic [N_REQ-1:0]      grant_d;
    logic [DATA_WIDTH-1:0] tx_data_d;
    logic [CTRL_WIDTH-1:0] tx_ctrl_d;
    logic                  busy_d;
    logic [31:0]           frame_count_d;
    logic                  abort_d;
    logic [IDW-1:0]        abort_id_d;

    logic                  win_found;
    logic [IDW-1:0]        win_id;
    logic [IDW-1:0]        cand;
    logic [DATA_WIDTH-1:0] cur_data;
    logic [CTRL_WIDTH-1:0] cur_ctrl;
    logic                  is_term;

    assign cur_data = i_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    assign cur_ctrl = i_ctrl[int'(grant_id)*CTRL_WIDTH +: CTRL_WIDTH];

    // Scan downward in priority so the requester closest above rr_ptr is assigned last and wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = IDW'((int'(rr_ptr) + i) % N_REQ);
            if (i_req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_comb begin
        is_term = 1'b0;
        for (int j = 0; j < CTRL_WIDTH; j++) begin
            if (cur_ctrl[j] && (cur_data[8*j +: 8] == TERM_CODE)) begin
                is_term = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state;
        rr_ptr_d      = rr_ptr;
        grant_id_d    = grant_id;
        grant_d       = o_grant;
        word_cnt_d    = word_cnt;
        ifg_cnt_d     = ifg_cnt;
        tx_data_d     = IDLE_WORD;
        tx_ctrl_d     = '1;
        frame_count_d = o_frame_count;
        abort_d       = 1'b0;
        abort_id_d    = o_abort_id;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_d    = SEND;
                    grant_id_d = win_id;
                    grant_d    = N_REQ'(1) << win_id;
                    rr_ptr_d   = IDW'((int'(win_id) + 1) % N_REQ);
                    word_cnt_d = '0;
                end
            end
            SEND: begin
                word_cnt_d = word_cnt + CW'(1);
                tx_data_d  = cur_data;
                tx_ctrl_d  = cur_ctrl;
                if (is_term) begin
                    grant_d       = '0;
                    frame_count_d = o_frame_count + 32'd1;
                    state_d       = IFG;
                    ifg_cnt_d     = 4'(MIN_IFG_WORDS - 1);
                end else if (word_cnt == CW'(MAX_FRAME_WORDS - 1)) begin
                    // Close the runaway frame ourselves so the downstream decoder sees a terminate.
                    tx_data_d  = ABORT_WORD;
                    tx_ctrl_d  = '1;
                    abort_d    = 1'b1;
                    abort_id_d = grant_id;
                    grant_d    = '0;
                    state_d    = IFG;
                    ifg_cnt_d  = 4'(MIN_IFG_WORDS - 1);
                end
            end
            IFG: begin
                if (ifg_cnt == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    ifg_cnt_d = ifg_cnt - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            grant_id      <= '0;
            word_cnt      <= '0;
            ifg_cnt       <= '0;
            o_grant       <= '0;
            o_tx_data     <= IDLE_WORD;
            o_tx_ctrl     <= '1;
            o_busy        <= 1'b0;
            o_frame_count <= '0;
            o_abort       <= 1'b0;
            o_abort_id    <= '0;
        end else begin
            state         <= state_d;
            rr_ptr        <= rr_ptr_d;
            grant_id      <= grant_id_d;
            word_cnt      <= word_cnt_d;
            ifg_cnt       <= ifg_cnt_d;
            o_grant       <= grant_d;
            o_tx_data     <= tx_data_d;
            o_tx_ctrl     <= tx_ctrl_d;
            o_busy        <= busy_d;
            o_frame_count <= frame_count_d;
            o_abort       <= abort_d;
            o_abort_id    <= abort_id_d;
        end
    end

endmodule

// File: tb/tb_mac_tx_scheduler.sv
// Directed bench for mac_tx_scheduler: cycle tables for single/round-robin/back-to-back
// frames, plus hand sequences for watchdog, term-at-max, mid-frame reset and fairness.
module tb_mac_tx_scheduler;

    localparam logic [63:0] IDLE_W  = {8{8'h07}};
    localparam logic [63:0] ABORT_W = {{7{8'h07}}, 8'hFD};

    logic         clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic [3:0]   i_req = '0;
    logic [255:0] i_data = '0;
    logic [31:0]  i_ctrl = '0;
    logic [3:0]   o_grant;
    logic [63:0]  o_tx_data;
    logic [7:0]   o_tx_ctrl;
    logic         o_busy;
    logic [31:0]  o_frame_count;
    logic         o_abort;
    logic [1:0]   o_abort_id;

    mac_tx_scheduler dut (
        .clk           (clk),
        .i_rst_n       (i_rst_n),
        .i_req         (i_req),
        .i_data        (i_data),
        .i_ctrl        (i_ctrl),
        .o_grant       (o_grant),
        .o_tx_data     (o_tx_data),
        .o_tx_ctrl     (o_tx_ctrl),
        .o_busy        (o_busy),
        .o_frame_count (o_frame_count),
        .o_abort       (o_abort),
        .o_abort_id    (o_abort_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic [3:0] grant;
        logic       busy;
        int         fc;
    } vec_t;

    vec_t        vecs[$];
    int          checks = 0;
    int          errors = 0;
    int          lens[4];
    int          idx[4];
    logic [63:0] prev_word[4];
    logic [7:0]  prev_ctrl[4];

    // Requester k word i of an l-word frame (l==0: never terminates); term lane is 7 for k==2, else 3.
    function automatic logic [63:0] mk_data(int k, int i, int l);
        logic [63:0] w;
        w = {8'(8'hA0 + k), 8'(i), 48'h0123_4567_89AB};
        if (i == 0) w[7:0] = 8'hFB;
        if (l > 0 && i == l - 1) begin
            if (k == 2) w[63:56] = 8'hFD;
            else        w[31:24] = 8'hFD;
        end
        return w;
    endfunction

    function automatic logic [7:0] mk_ctrl(int k, int i, int l);
        logic [7:0] c;
        c = 8'h00;
        if (i == 0) c = 8'h01;
        if (l > 0 && i == l - 1) c = (k == 2) ? 8'h80 : 8'h08;
        return c;
    endfunction

    function automatic int oh_idx(logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return 0;
    endfunction

    function automatic void add_frame(bit rst, logic [3:0] rq_first, logic [3:0] rq_rest,
                                      logic [3:0] g, int len, int fc);
        vec_t v;
        for (int r = 0; r <= len + 1; r++) begin
            v.rst   = rst && (r == 0);
            v.req   = (r == 0) ? rq_first : rq_rest;
            v.grant = (r < len) ? g : 4'b0000;
            v.busy  = (r <= len);
            v.fc    = (r < len) ? fc : fc + 1;
            vecs.push_back(v);
        end
    endfunction

    task automatic apply_stimulus();
        for (int k = 0; k < 4; k++) begin
            i_data[k*64 +: 64] = mk_data(k, idx[k], lens[k]);
            i_ctrl[k*8 +: 8]   = mk_ctrl(k, idx[k], lens[k]);
        end
    endtask

    // One clock: remember what each requester presented, then advance granted requesters.
    task automatic tick();
        logic [3:0] pre_g;
        for (int k = 0; k < 4; k++) begin
            prev_word[k] = mk_data(k, idx[k], lens[k]);
            prev_ctrl[k] = mk_ctrl(k, idx[k], lens[k]);
        end
        pre_g = o_grant;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (pre_g[k] && o_grant[k]) idx[k] = idx[k] + 1;
            else                        idx[k] = 0;
        end
        apply_stimulus();
    endtask

    task automatic check_output(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        i_req   = '0;
        i_rst_n = 1'b0;
        for (int k = 0; k < 4; k++) idx[k] = 0;
        apply_stimulus();
        repeat (2) @(posedge clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0]  prev_g;
        logic [63:0] exp_d;
        logic [7:0]  exp_c;
        logic        saw_abort;
        int          n;

        lens = '{10, 8, 3, 0};
        do_reset();
        $display("[TB] reset values");
        check_output("rst_grant", 64'(o_grant), 64'h0);
        check_output("rst_data", o_tx_data, IDLE_W);
        check_output("rst_ctrl", 64'(o_tx_ctrl), 64'hFF);
        check_output("rst_busy", 64'(o_busy), 64'h0);
        check_output("rst_fc", 64'(o_frame_count), 64'h0);
        check_output("rst_abort", 64'(o_abort), 64'h0);
        check_output("rst_abort_id", 64'(o_abort_id), 64'h0);

        // Single pulsed frame, round robin 0/2, back-to-back on requester 1.
        add_frame(1'b1, 4'b0001, 4'b0000, 4'b0001, 10, 0);
        vecs.push_back('{rst: 1'b0, req: 4'b0000, grant: 4'b0000, busy: 1'b0, fc: 1});
        add_frame(1'b1, 4'b0101, 4'b0101, 4'b0001, 10, 0);
        add_frame(1'b0, 4'b0101, 4'b0101, 4'b0100, 3, 1);
        add_frame(1'b0, 4'b0101, 4'b0101, 4'b0001, 10, 2);
        add_frame(1'b0, 4'b0101, 4'b0101, 4'b0100, 3, 3);
        add_frame(1'b1, 4'b0010, 4'b0010, 4'b0010, 8, 0);
        add_frame(1'b0, 4'b0010, 4'b0010, 4'b0010, 8, 1);

        $display("[TB] table vectors: %0d rows", vecs.size());
        prev_g = '0;
        foreach (vecs[r]) begin
            if (vecs[r].rst) begin
                do_reset();
                prev_g = '0;
            end
            i_req = vecs[r].req;
            tick();
            if (prev_g != 4'b0000) begin
                exp_d = prev_word[oh_idx(prev_g)];
                exp_c = prev_ctrl[oh_idx(prev_g)];
            end else begin
                exp_d = IDLE_W;
                exp_c = 8'hFF;
            end
            check_output($sformatf("row%0d_grant", r), 64'(o_grant), 64'(vecs[r].grant));
            check_output($sformatf("row%0d_busy", r), 64'(o_busy), 64'(vecs[r].busy));
            check_output($sformatf("row%0d_fc", r), 64'(o_frame_count), 64'(vecs[r].fc));
            check_output($sformatf("row%0d_data", r), o_tx_data, exp_d);
            check_output($sformatf("row%0d_ctrl", r), 64'(o_tx_ctrl), 64'(exp_c));
            check_output($sformatf("row%0d_abort", r), 64'(o_abort), 64'h0);
            prev_g = vecs[r].grant;
        end

        $display("[TB] watchdog on requester 3");
        do_reset();
        i_req = 4'b1000;
        tick();
        check_output("wd_grant", 64'(o_grant), 64'h8);
        i_req = 4'b0000;
        saw_abort = 1'b0;
        repeat (191) begin
            tick();
            if (o_abort) saw_abort = 1'b1;
        end
        check_output("wd_no_early_abort", 64'(saw_abort), 64'h0);
        check_output("wd_word191_data", o_tx_data, prev_word[3]);
        check_output("wd_still_granted", 64'(o_grant), 64'h8);
        tick();
        check_output("wd_abort", 64'(o_abort), 64'h1);
        check_output("wd_abort_id", 64'(o_abort_id), 64'h3);
        check_output("wd_abort_data", o_tx_data, ABORT_W);
        check_output("wd_abort_ctrl", 64'(o_tx_ctrl), 64'hFF);
        check_output("wd_grant_clr", 64'(o_grant), 64'h0);
        check_output("wd_fc", 64'(o_frame_count), 64'h0);
        tick();
        check_output("wd_abort_pulse", 64'(o_abort), 64'h0);
        check_output("wd_abort_id_hold", 64'(o_abort_id), 64'h3);
        check_output("wd_idle_after", o_tx_data, IDLE_W);

        $display("[TB] term at max frame length");
        lens[1] = 192;
        do_reset();
        i_req = 4'b0010;
        tick();
        i_req = 4'b0000;
        repeat (192) tick();
        check_output("max_no_abort", 64'(o_abort), 64'h0);
        check_output("max_fc", 64'(o_frame_count), 64'h1);
        check_output("max_grant_clr", 64'(o_grant), 64'h0);
        check_output("max_term_data", o_tx_data, prev_word[1]);
        check_output("max_term_ctrl", 64'(o_tx_ctrl), 64'h08);
        check_output("max_abort_id", 64'(o_abort_id), 64'h0);
        lens[1] = 8;

        $display("[TB] reset mid-frame, then fairness");
        do_reset();
        i_req = 4'b0001;
        tick();
        i_req = 4'b0000;
        repeat (5) tick();
        #2;
        i_rst_n = 1'b0;
        #1;
        check_output("mid_rst_grant", 64'(o_grant), 64'h0);
        check_output("mid_rst_data", o_tx_data, IDLE_W);
        check_output("mid_rst_ctrl", 64'(o_tx_ctrl), 64'hFF);
        check_output("mid_rst_busy", 64'(o_busy), 64'h0);
        lens = '{2, 2, 2, 2};
        for (int k = 0; k < 4; k++) idx[k] = 0;
        i_req = 4'b1111;
        apply_stimulus();
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;
        for (int f = 0; f < 5; f++) begin
            n = 0;
            while (o_grant == 4'b0000 && n < 20) begin
                tick();
                n++;
            end
            check_output($sformatf("fair_grant%0d", f), 64'(o_grant), 64'(4'b0001 << (f % 4)));
            n = 0;
            while (o_grant != 4'b0000 && n < 20) begin
                tick();
                n++;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
